// File: rtl/inert_ctrl_if.sv
// Bundle between inert_ctrl, the shared SPI master and inertial_integrator.
// master = the sequencer side; slave = the SPI master / consumer side.
interface inert_ctrl_if;
    localparam int unsigned WORD_W = 16;

    logic              INT;
    logic              done;
    logic [WORD_W-1:0] rd_data;
    logic              wrt;
    logic [WORD_W-1:0] cmd;
    logic              vld;
    logic [WORD_W-1:0] ptch_rt;
    logic [WORD_W-1:0] AZ;

    modport master (
        input  INT, done, rd_data,
        output wrt, cmd, vld, ptch_rt, AZ
    );

    modport slave (
        output INT, done, rd_data,
        input  wrt, cmd, vld, ptch_rt, AZ
    );
endinterface

// File: rtl/inert_ctrl.sv
// IMU sequencer: power-up wait, 4 SPI config writes, then on each data-ready
// interrupt 4 SPI reads assembled into ptch_rt/AZ with a one-cycle vld pulse.
module inert_ctrl #(
    parameter int unsigned INIT_WAIT_BITS = 16
) (
    input  logic         clk,
    input  logic         rst,
    inert_ctrl_if.master bus
);
    localparam int unsigned NXFER  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 16;

    localparam logic [INIT_WAIT_BITS-1:0] TIMER_LAST = '1;
    localparam logic [INIT_WAIT_BITS-1:0] TIMER_PRE  = TIMER_LAST - INIT_WAIT_BITS'(1);

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_WR,
        S_WR_WAIT,
        S_WAIT_INT,
        S_RD,
        S_RD_WAIT,
        S_VLD
    } state_t;

    function automatic logic [CMD_W-1:0] init_cmd(input logic [IDX_W-1:0] i);
        case (i)
            2'd0:    init_cmd = 16'h0D02;
            2'd1:    init_cmd = 16'h1053;
            2'd2:    init_cmd = 16'h1150;
            default: init_cmd = 16'h1460;
        endcase
    endfunction

    // Read order: pitch L, pitch H, AZ L, AZ H.
    function automatic logic [CMD_W-1:0] rd_cmd(input logic [IDX_W-1:0] i);
        case (i)
            2'd0:    rd_cmd = 16'hA200;
            2'd1:    rd_cmd = 16'hA300;
            2'd2:    rd_cmd = 16'hAC00;
            default: rd_cmd = 16'hAD00;
        endcase
    endfunction

    state_t                           state;
    logic [INIT_WAIT_BITS-1:0]        timer;
    logic [IDX_W-1:0]                 idx;
    logic [NXFER-1:0][BYTE_W-1:0]     rd_bytes;
    logic                             int_s1;
    logic                             int_s2;
    logic                             last_xfer;
    logic                             done_ok;
    logic                             unused_hi;

    assign last_xfer = (idx == IDX_W'(NXFER - 1));
    // A done coinciding with our own start pulse cannot belong to this transaction.
    assign done_ok   = bus.done && !bus.wrt;
    assign unused_hi = ^bus.rd_data[CMD_W-1:BYTE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT_WAIT;
            timer       <= '0;
            idx         <= '0;
            rd_bytes    <= '0;
            int_s1      <= 1'b0;
            int_s2      <= 1'b0;
            bus.wrt     <= 1'b0;
            bus.cmd     <= '0;
            bus.vld     <= 1'b0;
            bus.ptch_rt <= '0;
            bus.AZ      <= '0;
        end else begin
            int_s1  <= bus.INT;
            int_s2  <= int_s1;
            bus.wrt <= 1'b0;
            bus.vld <= 1'b0;
            case (state)
                S_INIT_WAIT: begin
                    if (timer != TIMER_LAST) timer <= timer + INIT_WAIT_BITS'(1);
                    if (timer == TIMER_PRE || timer == TIMER_LAST) state <= S_WR;
                end
                S_WR: begin
                    bus.wrt <= 1'b1;
                    bus.cmd <= init_cmd(idx);
                    state   <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (done_ok) begin
                        if (last_xfer) begin
                            idx   <= '0;
                            state <= S_WAIT_INT;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_WR;
                        end
                    end
                end
                S_WAIT_INT: begin
                    if (int_s2) state <= S_RD;
                end
                S_RD: begin
                    bus.wrt <= 1'b1;
                    bus.cmd <= rd_cmd(idx);
                    state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (done_ok) begin
                        rd_bytes[idx] <= bus.rd_data[BYTE_W-1:0];
                        if (last_xfer) begin
                            idx   <= '0;
                            state <= S_VLD;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_RD;
                        end
                    end
                end
                S_VLD: begin
                    bus.vld     <= 1'b1;
                    bus.ptch_rt <= {rd_bytes[1], rd_bytes[0]};
                    bus.AZ      <= {rd_bytes[3], rd_bytes[2]};
                    state       <= S_WAIT_INT;
                end
                default: state <= S_INIT_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_inert_ctrl.sv
// Self-checking bench for inert_ctrl: SPI slave model, command-order and
// output-hold scoreboard, table vectors, random sets and multi-cycle corners.
module tb_inert_ctrl;
    localparam int unsigned IWB      = 4;
    localparam int unsigned DONE_LAT = 8;
    localparam int unsigned NVEC     = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inert_ctrl_if bus ();

    inert_ctrl #(.INIT_WAIT_BITS(IWB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [15:0] exp_ptch;
        logic [15:0] exp_az;
    } vec_t;

    vec_t        vecs [NVEC];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    logic [7:0]  cur_b [4];
    int          wr_wrt = 0, rd_wrt = 0, vld_count = 0;
    int          exp_k, first_wrt_cyc, pending, cnt;
    bit          first_seen;
    logic [15:0] held, last_p, last_a;
    logic        prev_vld;
    int          spur_req_n = 0, spur_ack_n = 0;
    bit          spur_with_wrt = 0;

    always_ff @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected command stream: config writes, then read commands forever.
    function automatic logic [15:0] exp_cmd(input int k);
        int r;
        if (k < 4) begin
            case (k)
                0:       return 16'h0D02;
                1:       return 16'h1053;
                2:       return 16'h1150;
                default: return 16'h1460;
            endcase
        end
        r = (k - 4) % 4;
        case (r)
            0:       return 16'hA200;
            1:       return 16'hA300;
            2:       return 16'hAC00;
            default: return 16'hAD00;
        endcase
    endfunction

    function automatic logic [7:0] serve(input logic [15:0] c);
        case (c[14:8])
            7'h22:   return cur_b[0];
            7'h23:   return cur_b[1];
            7'h2C:   return cur_b[2];
            7'h2D:   return cur_b[3];
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] model_ptch();
        return 16'(cur_b[1]) * 16'd256 + 16'(cur_b[0]);
    endfunction

    function automatic logic [15:0] model_az();
        return 16'(cur_b[3]) * 16'd256 + 16'(cur_b[2]);
    endfunction

    // SPI slave: done DONE_LAT cycles after each wrt, plus injected spurious dones.
    task automatic run_spi();
        bus.done    = 1'b0;
        bus.rd_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending    = 0;
                cnt        = 0;
                exp_k      = 0;
                first_seen = 0;
                bus.done   = 1'b0;
                spur_ack_n = spur_req_n;
            end else begin
                bus.done = 1'b0;
                if (spur_ack_n != spur_req_n) begin
                    bus.done   = 1'b1;
                    spur_ack_n = spur_req_n;
                end
                if (bus.wrt) begin
                    chk("one_outstanding", 32'(pending), 32'd0);
                    chk("cmd_order", 32'(bus.cmd), 32'(exp_cmd(exp_k)));
                    if (!first_seen) begin
                        first_seen    = 1;
                        first_wrt_cyc = cyc;
                    end
                    if (exp_k >= 4) rd_wrt++;
                    else            wr_wrt++;
                    exp_k++;
                    held    = bus.cmd;
                    pending = 1;
                    cnt     = DONE_LAT;
                    if (spur_with_wrt) bus.done = 1'b1;
                end else if (pending != 0) begin
                    chk("cmd_stable", 32'(bus.cmd), 32'(held));
                    cnt--;
                    if (cnt == 0) begin
                        pending     = 0;
                        bus.done    = 1'b1;
                        bus.rd_data = {8'($urandom), serve(held)};
                    end
                end
            end
        end
    endtask

    // Output monitor: vld values against the model, hold between pulses.
    task automatic run_mon();
        prev_vld = 1'b0;
        last_p   = '0;
        last_a   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_p   = '0;
                last_a   = '0;
                prev_vld = 1'b0;
            end else begin
                if (bus.vld) begin
                    vld_count++;
                    chk("vld_single_cycle", 32'(prev_vld), 32'd0);
                    chk("vld_ptch", 32'(bus.ptch_rt), 32'(model_ptch()));
                    chk("vld_az", 32'(bus.AZ), 32'(model_az()));
                    last_p = bus.ptch_rt;
                    last_a = bus.AZ;
                end else begin
                    chk("hold_ptch", 32'(bus.ptch_rt), 32'(last_p));
                    chk("hold_az", 32'(bus.AZ), 32'(last_a));
                end
                prev_vld = bus.vld;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0:       return wr_wrt;
            1:       return rd_wrt;
            default: return vld_count;
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input int limit, input string name);
        int k = 0;
        while (get_cnt(which) < target && k < limit) begin
            step(1);
            k++;
        end
        chk(name, 32'(get_cnt(which) >= target), 32'd1);
    endtask

    // One read set: pulse INT until the first read starts, then wait for vld.
    task automatic run_set(input string name);
        int r0, v0;
        r0 = rd_wrt;
        v0 = vld_count;
        bus.INT = 1'b1;
        wait_cnt(1, r0 + 1, 100, {name, "_start"});
        bus.INT = 1'b0;
        wait_cnt(2, v0 + 1, 200, {name, "_vld"});
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 4; i++) cur_b[i] = 8'($urandom);
    endtask

    task automatic reset_out_checks(input string name);
        chk({name, "_wrt"}, 32'(bus.wrt), 32'd0);
        chk({name, "_vld"}, 32'(bus.vld), 32'd0);
        chk({name, "_cmd"}, 32'(bus.cmd), 32'd0);
        chk({name, "_ptch"}, 32'(bus.ptch_rt), 32'd0);
        chk({name, "_az"}, 32'(bus.AZ), 32'd0);
    endtask

    initial begin
        int r0, v0, w0, t0;
        vecs[0] = '{8'h34, 8'h12, 8'h80, 8'hFE, 16'h1234, 16'hFE80};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 16'hFFFF, 16'h7FFF};
        vecs[3] = '{8'h01, 8'h80, 8'h00, 8'h80, 16'h8001, 16'h8000};
        vecs[4] = '{8'hAA, 8'h55, 8'h55, 8'hAA, 16'h55AA, 16'hAA55};

        rst     = 1'b1;
        bus.INT = 1'b0;
        for (int i = 0; i < 4; i++) cur_b[i] = 8'h00;
        fork
            run_spi();
            run_mon();
        join_none

        step(3);
        reset_out_checks("reset");
        rst = 1'b0;

        // Power-up wait and the four config writes.
        wait_cnt(0, 4, 300, "init_writes_done");
        step(DONE_LAT + 4);
        chk("init_write_count", 32'(wr_wrt), 32'd4);
        chk("first_wrt_cycle", 32'(first_wrt_cyc), 32'd16);

        // Spurious done while idle in WAIT_INT.
        t0 = wr_wrt + rd_wrt;
        v0 = vld_count;
        spur_req_n++;
        step(8);
        chk("spur_idle_no_wrt", 32'(wr_wrt + rd_wrt), 32'(t0));
        chk("spur_idle_no_vld", 32'(vld_count), 32'(v0));

        // Table vectors.
        for (int i = 0; i < NVEC; i++) begin
            cur_b[0] = vecs[i].b0;
            cur_b[1] = vecs[i].b1;
            cur_b[2] = vecs[i].b2;
            cur_b[3] = vecs[i].b3;
            r0 = rd_wrt;
            v0 = vld_count;
            run_set("vec");
            chk("vec_ptch", 32'(bus.ptch_rt), 32'(vecs[i].exp_ptch));
            chk("vec_az", 32'(bus.AZ), 32'(vecs[i].exp_az));
            step(30);
            chk("vec_ptch_held", 32'(bus.ptch_rt), 32'(vecs[i].exp_ptch));
            chk("vec_reads", 32'(rd_wrt - r0), 32'd4);
            chk("vec_vld_count", 32'(vld_count - v0), 32'd1);
        end

        // Random read sets.
        for (int i = 0; i < 6; i++) begin
            rand_bytes();
            r0 = rd_wrt;
            run_set("rand");
            chk("rand_ptch", 32'(bus.ptch_rt), 32'(model_ptch()));
            chk("rand_az", 32'(bus.AZ), 32'(model_az()));
            step(10);
            chk("rand_reads", 32'(rd_wrt - r0), 32'd4);
        end

        // INT held high: back-to-back sets; the set already latched by the
        // synchronizer when INT drops still completes.
        rand_bytes();
        r0 = rd_wrt;
        v0 = vld_count;
        bus.INT = 1'b1;
        wait_cnt(2, v0 + 3, 600, "b2b_three_vld");
        chk("b2b_reads_at_third_vld", 32'(rd_wrt - r0), 32'd12);
        bus.INT = 1'b0;
        step(150);
        chk("b2b_total_vld", 32'(vld_count - v0), 32'd4);
        chk("b2b_total_reads", 32'(rd_wrt - r0), 32'd16);

        // done in the same cycle as wrt must be ignored.
        rand_bytes();
        r0 = rd_wrt;
        v0 = vld_count;
        spur_with_wrt = 1;
        run_set("samecyc");
        spur_with_wrt = 0;
        step(30);
        chk("samecyc_reads", 32'(rd_wrt - r0), 32'd4);
        chk("samecyc_vld", 32'(vld_count - v0), 32'd1);
        chk("samecyc_ptch", 32'(bus.ptch_rt), 32'(model_ptch()));

        // One-cycle INT glitch during a read wait.
        rand_bytes();
        r0 = rd_wrt;
        v0 = vld_count;
        bus.INT = 1'b1;
        wait_cnt(1, r0 + 1, 100, "glitch_start");
        bus.INT = 1'b0;
        wait_cnt(1, r0 + 2, 100, "glitch_second_read");
        step(2);
        bus.INT = 1'b1;
        step(1);
        bus.INT = 1'b0;
        step(150);
        chk("glitch_reads", 32'(rd_wrt - r0), 32'd4);
        chk("glitch_vld", 32'(vld_count - v0), 32'd1);

        // Reset during the third read wait, then full re-init before reading.
        rand_bytes();
        r0 = rd_wrt;
        v0 = vld_count;
        bus.INT = 1'b1;
        wait_cnt(1, r0 + 3, 150, "rst_third_read");
        step(2);
        #1 rst = 1'b1;
        #1 reset_out_checks("midrst");
        chk("midrst_no_vld", 32'(vld_count), 32'(v0));
        step(3);
        rst = 1'b0;
        w0 = wr_wrt;
        r0 = rd_wrt;
        wait_cnt(1, r0 + 1, 400, "reinit_first_read");
        bus.INT = 1'b0;
        chk("reinit_writes", 32'(wr_wrt - w0), 32'd4);
        chk("reinit_first_wrt_cycle", 32'(first_wrt_cyc), 32'd16);
        wait_cnt(2, v0 + 1, 200, "reinit_vld");
        chk("reinit_ptch", 32'(bus.ptch_rt), 32'(model_ptch()));
        chk("reinit_az", 32'(bus.AZ), 32'(model_az()));
        step(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
